image_quan_para_loader: RTL and testbench

- Writer side of the quantisation parameter table in image_conv_quan. That table holds 45 words of 256 bits: weights at 0-31, bias, scale, shift, and zero point.
- Accepts 64-bit parameter beats from the DMA stream and packs each group of 4 beats into one 256-bit word.
- Drives weight_addrb/weight_data_in with consecutive addresses, starting at a programmed base, for a programmed word count.
- Sits between the parameter DMA channel and image_conv_quan. It is started by the layer controller.

---
 rtl/image_quan_para_loader_if.sv | 26 ++
 rtl/image_quan_para_loader.sv | 68 ++++++
 tb/tb_image_quan_para_loader.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/image_quan_para_loader_if.sv
// image_quan_para_loader_if: start/config, parameter stream and table-write signals of the loader
interface image_quan_para_loader_if #(
    parameter int WIDTH_S_DATA = 64,
    parameter int WIDTH_PARA = 256,
    parameter int WIDTH_ADDR = 6
);
    logic Start;
    logic [WIDTH_ADDR-1:0] Start_Addr_REG;
    logic [WIDTH_ADDR-1:0] Para_Num_REG;
    logic S_Valid;
    logic [WIDTH_S_DATA-1:0] S_Data;
    logic S_Ready;
    logic [WIDTH_ADDR-1:0] weight_addrb;
    logic [WIDTH_PARA-1:0] weight_data_in;
    logic Wr_Valid;
    logic Busy;
    logic Load_Done;
    modport master (
        output Start, Start_Addr_REG, Para_Num_REG, S_Valid, S_Data,
        input S_Ready, weight_addrb, weight_data_in, Wr_Valid, Busy, Load_Done
    );
    modport slave (
        input Start, Start_Addr_REG, Para_Num_REG, S_Valid, S_Data,
        output S_Ready, weight_addrb, weight_data_in, Wr_Valid, Busy, Load_Done
    );
endinterface

// File: rtl/image_quan_para_loader.sv
// image_quan_para_loader: packs 4 stream beats per 256-bit word and writes consecutive quantisation-table addresses
module image_quan_para_loader #(
    parameter int WIDTH_S_DATA = 64,
    parameter int WIDTH_PARA = 256,
    parameter int WIDTH_ADDR = 6,
    parameter int PARA_DEPTH = 45
) (
    input logic clk,
    input logic rst,
    image_quan_para_loader_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
    state_t state, state_nxt;
    logic [WIDTH_ADDR-1:0] base, num, word_cnt, cur_addr;
    logic [1:0] beat_cnt;
    logic [WIDTH_PARA-WIDTH_S_DATA-1:0] pack;
    logic accept, last_beat, last_word;
    assign cur_addr = base + word_cnt;
    assign accept = bus.S_Valid && bus.S_Ready;
    assign last_beat = accept && beat_cnt == 2'd3;
    assign last_word = word_cnt == num - 1'b1;
    assign bus.S_Ready = state == LOAD;
    assign bus.Busy = state != IDLE;
    assign bus.Load_Done = state == DONE;
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = IDLE;
        if (state == IDLE) state_nxt = bus.Start ? (bus.Para_Num_REG != '0 ? LOAD : DONE) : IDLE;
        else if (state == LOAD) state_nxt = last_beat && last_word ? DONE : LOAD;
    end
    // Address/data only change on an emitted word so the consumer's every-cycle write stays idempotent.
    always_ff @(posedge clk) begin
        if (!rst) begin
            base <= '0;
            num <= '0;
            word_cnt <= '0;
            beat_cnt <= '0;
            pack <= '0;
            bus.weight_addrb <= '0;
            bus.weight_data_in <= '0;
            bus.Wr_Valid <= 1'b0;
        end else begin
            bus.Wr_Valid <= 1'b0;
            if (state == IDLE && bus.Start) begin
                base <= bus.Start_Addr_REG;
                num <= bus.Para_Num_REG;
                word_cnt <= '0;
                beat_cnt <= '0;
            end
            if (accept) begin
                beat_cnt <= beat_cnt + 1'b1;
                for (int i = 0; i < 3; i++)
                    if (beat_cnt == 2'(i)) pack[i*WIDTH_S_DATA +: WIDTH_S_DATA] <= bus.S_Data;
                if (beat_cnt == 2'd3) begin
                    word_cnt <= word_cnt + 1'b1;
                    if (cur_addr <= WIDTH_ADDR'(PARA_DEPTH - 1)) begin
                        bus.weight_addrb <= cur_addr;
                        bus.weight_data_in <= {bus.S_Data, pack};
                        bus.Wr_Valid <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_image_quan_para_loader.sv
// tb_image_quan_para_loader: scoreboard bench for the quantisation parameter loader
module tb_image_quan_para_loader;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    image_quan_para_loader_if bus();
    image_quan_para_loader dut (.clk(clk), .rst(rst), .bus(bus));
    typedef struct {
        logic [5:0] addr;
        logic [255:0] data;
        int cyc;
    } exp_t;
    exp_t sb[$];
    int cyc = 0, n_chk = 0, n_pass = 0;
    int wr_cnt = 0, done_cnt = 0, done_cyc = -1, rdy_cnt = 0;
    logic [63:0] nb;
    logic [5:0] last_addr;
    logic [255:0] last_data;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst) begin
            if (bus.Wr_Valid) begin
                wr_cnt++;
                if (sb.size() == 0) check("wr_extra", 256'(sb.size()), 256'(1));
                else begin
                    e = sb.pop_front();
                    check("wr_addr", 256'(bus.weight_addrb), 256'(e.addr));
                    check("wr_data", bus.weight_data_in, e.data);
                    check("wr_cyc", 256'(cyc), 256'(e.cyc));
                end
            end
            if (bus.Load_Done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (bus.S_Ready) rdy_cnt++;
        end
    end
    task automatic zero_check(input string tag);
        check({tag, "_addr"}, 256'(bus.weight_addrb), 256'(0));
        check({tag, "_data"}, bus.weight_data_in, 256'(0));
        check({tag, "_wrv"}, 256'(bus.Wr_Valid), 256'(0));
        check({tag, "_busy"}, 256'(bus.Busy), 256'(0));
        check({tag, "_done"}, 256'(bus.Load_Done), 256'(0));
        check({tag, "_rdy"}, 256'(bus.S_Ready), 256'(0));
    endtask
    task automatic send(input logic [63:0] d, output int hs);
        bit ok = 1'b0;
        bus.S_Valid = 1'b1;
        bus.S_Data = d;
        hs = -1;
        for (int i = 0; i < 50; i++) begin
            ok = bus.S_Ready;
            @(posedge clk);
            #1;
            if (ok) begin
                hs = cyc;
                break;
            end
        end
        check("beat_hs", 256'(ok), 256'(1));
    endtask
    task automatic load(input logic [5:0] base, input logic [5:0] num, input bit gap, input bit poke, input int cut);
        int w0, d0, r0, hs, last_hs, pushes;
        logic [255:0] word;
        logic [5:0] a;
        w0 = wr_cnt;
        d0 = done_cnt;
        r0 = rdy_cnt;
        pushes = 0;
        word = '0;
        bus.Start = 1'b1;
        bus.Start_Addr_REG = base;
        bus.Para_Num_REG = num;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        bus.Start_Addr_REG = ~base;
        bus.Para_Num_REG = num + 6'd3;
        last_hs = cyc;
        check("busy_on", 256'(bus.Busy), 256'(1));
        for (int w = 0; w < int'(num); w++)
            for (int b = 0; b < 4; b++) begin
                if (cut != 0 && w * 4 + b == cut) begin
                    bus.S_Valid = 1'b0;
                    rst = 1'b0;
                    @(posedge clk);
                    #1;
                    zero_check("mid_rst");
                    check("mid_rst_sb", 256'(sb.size()), 256'(0));
                    rst = 1'b1;
                    last_addr = '0;
                    last_data = '0;
                    return;
                end
                if (gap) begin
                    bus.S_Valid = 1'b0;
                    @(posedge clk);
                    #1;
                end
                if (poke && ((w == 1 && b == 1) || (w == int'(num) - 1 && b == 3))) begin
                    bus.Start = 1'b1;
                    bus.Start_Addr_REG = 6'd10;
                    bus.Para_Num_REG = 6'd3;
                end
                send(nb, hs);
                bus.Start = 1'b0;
                word[b*64 +: 64] = nb;
                nb++;
                last_hs = hs;
                if (b == 3) begin
                    a = base + 6'(w);
                    if (a <= 6'd44) begin
                        sb.push_back('{addr: a, data: word, cyc: hs});
                        last_addr = a;
                        last_data = word;
                        pushes++;
                    end
                end
            end
        bus.S_Valid = 1'b0;
        for (int i = 0; i < 10 && done_cnt == d0; i++) begin
            @(posedge clk);
            #1;
        end
        check("done_once", 256'(done_cnt - d0), 256'(1));
        check("done_cyc", 256'(done_cyc), 256'(last_hs));
        check("wr_count", 256'(wr_cnt - w0), 256'(pushes));
        check("sb_empty", 256'(sb.size()), 256'(0));
        if (num == 0) check("rdy_zero", 256'(rdy_cnt - r0), 256'(0));
        check("idle_busy", 256'(bus.Busy), 256'(0));
        check("idle_rdy", 256'(bus.S_Ready), 256'(0));
        check("idle_done", 256'(bus.Load_Done), 256'(0));
        check("hold_addr", 256'(bus.weight_addrb), 256'(last_addr));
        check("hold_data", bus.weight_data_in, last_data);
        repeat (2) @(posedge clk);
        #1;
        check("stay_idle", 256'(bus.Busy), 256'(0));
    endtask
    initial begin
        bus.Start = 1'b0;
        bus.Start_Addr_REG = '0;
        bus.Para_Num_REG = '0;
        bus.S_Valid = 1'b0;
        bus.S_Data = '0;
        repeat (3) @(posedge clk);
        #1;
        zero_check("reset");
        rst = 1'b1;
        last_addr = '0;
        last_data = '0;
        nb = '0;
        load(6'd0, 6'd45, 1'b0, 1'b0, 0);
        load(6'd32, 6'd4, 1'b1, 1'b0, 0);
        load(6'd0, 6'd0, 1'b0, 1'b0, 0);
        load(6'd43, 6'd4, 1'b0, 1'b0, 0);
        load(6'd0, 6'd2, 1'b0, 1'b0, 7);
        load(6'd0, 6'd1, 1'b0, 1'b0, 0);
        load(6'd5, 6'd6, 1'b0, 1'b1, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
